ddr_out_serialiser: RTL and testbench

Converts WIDTH-bit words into bit pairs for a downstream ODDR2 output register. Words arrive on a valid/ready handshake, and two bits leave per clock on `d0_o` (for the C0 edge) and `d1_o` (for the C1 edge). A single holding register sits in front of a shift register, so streams of WIDTH≥4 run gapless. The block sits between the SPI/acquisition word sources and the IOB ODDR2 primitive.

---
 rtl/ddr_out_serialiser_pkg.sv | 8 +
 rtl/ddr_out_serialiser.sv | 102 ++++++++++
 tb/tb_ddr_out_serialiser.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_out_serialiser_pkg.sv
// Helpers shared by the ODDR2 output serialiser.
package ddr_out_serialiser_pkg;

  function automatic bit width_is_legal(input int w);
    return (w >= 2) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/ddr_out_serialiser.sv
// Word-to-bit-pair serialiser feeding an ODDR2: d0_o goes out on C0, d1_o on C1.
// One holding register in front of the shifter keeps streams gapless for WIDTH >= 4.
module ddr_out_serialiser
  import ddr_out_serialiser_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE      = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             d0_o,
  output logic             d1_o,
  output logic             frame_o,
  output logic             sof_o
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = $clog2(HALF + 1);
  // Bit positions of the pair that leaves next; the shifter moves data toward them.
  localparam int HI = MSB_FIRST ? WIDTH - 1 : 0;
  localparam int LO = MSB_FIRST ? WIDTH - 2 : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (!width_is_legal(WIDTH)) begin : g_bad_width
      $error("ddr_out_serialiser: WIDTH must be even and >= 2");
    end
  endgenerate

  logic             r_holdV;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_srNext;

  assign ready_o  = !r_holdV && !rst_i;
  assign w_accept = valid_i && ready_o;
  // Loading while the last pair is on the wire is what makes back-to-back words gapless.
  assign w_load   = r_holdV && (r_cnt <= CNT_ONE);
  assign w_shift  = (r_cnt != '0) && !w_load;
  assign w_srNext = MSB_FIRST ? (r_sr << 2) : (r_sr >> 2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_holdV <= 1'b0;
      r_hold  <= '0;
    end else if (w_accept) begin
      r_holdV <= 1'b1;
      r_hold  <= data_i;
    end else if (w_load) begin
      r_holdV <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_sr  <= r_hold;
      r_cnt <= CNT_LOAD;
    end else if (w_shift) begin
      r_sr  <= w_srNext;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // The pair registered here is the one the shifter holds after this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d0_o    <= IDLE;
      d1_o    <= IDLE;
      frame_o <= 1'b0;
      sof_o   <= 1'b0;
    end else if (w_load) begin
      d0_o    <= r_hold[HI];
      d1_o    <= r_hold[LO];
      frame_o <= 1'b1;
      sof_o   <= 1'b1;
    end else if (w_shift && (r_cnt > CNT_ONE)) begin
      d0_o    <= w_srNext[HI];
      d1_o    <= w_srNext[LO];
      frame_o <= 1'b1;
      sof_o   <= 1'b0;
    end else begin
      d0_o    <= IDLE;
      d1_o    <= IDLE;
      frame_o <= 1'b0;
      sof_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_out_serialiser.sv
// Self-checking bench for ddr_out_serialiser: an 8-bit MSB-first instance and a
// 2-bit LSB-first instance, compared against a per-edge schedule of expected pairs.
module tb_ddr_out_serialiser;

  localparam int NWORDS = 200;
  localparam int LIMIT  = 4000;

  logic       clk = 1'b0;
  logic       rst;

  logic       validA;
  logic [7:0] dataA;
  logic       readyA, d0A, d1A, frameA, sofA;

  logic       validB;
  logic [1:0] dataB;
  logic       readyB, d0B, d1B, frameB, sofB;

  int checks = 0;
  int errors = 0;

  // Expected {frame, sof, d0, d1} after each edge of the stalled-source run.
  logic [3:0] expOut [0:LIMIT+15];
  logic [7:0] stallWords [0:NWORDS-1];

  always #5 clk = ~clk;

  ddr_out_serialiser #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE(1'b0)) dutA (
    .clk_i(clk), .rst_i(rst), .valid_i(validA), .ready_o(readyA), .data_i(dataA),
    .d0_o(d0A), .d1_o(d1A), .frame_o(frameA), .sof_o(sofA)
  );

  ddr_out_serialiser #(.WIDTH(2), .MSB_FIRST(1'b0), .IDLE(1'b0)) dutB (
    .clk_i(clk), .rst_i(rst), .valid_i(validB), .ready_o(readyB), .data_i(dataB),
    .d0_o(d0B), .d1_o(d1B), .frame_o(frameB), .sof_o(sofB)
  );

  task automatic test_reset();
    rst = 1'b1;
    validA = 1'b0; dataA = 8'h00;
    validB = 1'b0; dataB = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({readyA, frameA, sofA, d0A, d1A} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_a got %b want %b", {readyA, frameA, sofA, d0A, d1A}, 5'b00000);
    end
    checks++;
    if ({readyB, frameB, sofB, d0B, d1B} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_b got %b want %b", {readyB, frameB, sofB, d0B, d1B}, 5'b00000);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({readyA, readyB} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b want %b", {readyA, readyB}, 2'b11);
    end
    @(negedge clk);
    checks++;
    if ({frameA, frameB} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_idle_frame got %b want %b", {frameA, frameB}, 2'b00);
    end
  endtask

  task automatic test_single_word();
    logic [1:0] expPair [4];
    logic [7:0] bits;
    expPair = '{2'b10, 2'b11, 2'b01, 2'b00};
    bits = 8'h00;
    @(negedge clk);
    validA = 1'b1; dataA = 8'hB4;
    checks++;
    if (readyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_ready got %b want %b", readyA, 1'b1);
    end
    @(negedge clk);
    validA = 1'b0; dataA = 8'h00;
    checks++;
    if ({frameA, readyA} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_hold_stage got %b want %b", {frameA, readyA}, 2'b00);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if ({frameA, sofA, d0A, d1A} !== {1'b1, 1'(j == 0), expPair[j]}) begin
        errors++;
        $display("[TB] FAIL single_pair%0d got %b want %b", j, {frameA, sofA, d0A, d1A},
                 {1'b1, 1'(j == 0), expPair[j]});
      end
      bits = {bits[5:0], d0A, d1A};
    end
    @(negedge clk);
    checks++;
    if ({frameA, sofA, d0A, d1A} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_end_idle got %b want %b", {frameA, sofA, d0A, d1A}, 4'b0000);
    end
    checks++;
    if (bits !== 8'b1011_0100) begin
      errors++;
      $display("[TB] FAIL single_q_sequence got %b want %b", bits, 8'b1011_0100);
    end
  endtask

  task automatic test_saturated();
    logic [7:0]  words [3];
    int          hsEdge [3];
    int          idx, frames, run, bestRun;
    logic [23:0] bits;
    logic        hs;
    words = '{8'hFF, 8'h00, 8'hA5};
    hsEdge = '{0, 0, 0};
    idx = 0; frames = 0; run = 0; bestRun = 0; bits = '0;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (idx < 3) begin
        validA = 1'b1; dataA = words[idx];
      end else begin
        validA = 1'b0; dataA = 8'h00;
      end
      hs = validA && readyA;
      @(negedge clk);
      if (hs) begin
        hsEdge[idx] = c;
        idx++;
      end
      if (frameA) begin
        frames++; run++;
        bits = {bits[21:0], d0A, d1A};
      end else begin
        run = 0;
      end
      if (run > bestRun) bestRun = run;
    end
    validA = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("[TB] FAIL sat_accepted got %0d want %0d", idx, 3);
    end
    checks++;
    if (frames != 12 || bestRun != 12) begin
      errors++;
      $display("[TB] FAIL sat_frame_run got frames=%0d run=%0d want 12/12", frames, bestRun);
    end
    checks++;
    if (bits !== 24'hFF00A5) begin
      errors++;
      $display("[TB] FAIL sat_bits got %h want %h", bits, 24'hFF00A5);
    end
    // Next word is taken the cycle after the previous one moves from hold to shifter.
    checks++;
    if ((hsEdge[1] - hsEdge[0]) != 2 || (hsEdge[2] - hsEdge[1]) != 4) begin
      errors++;
      $display("[TB] FAIL sat_handshake_spacing got %0d,%0d want 2,4",
               hsEdge[1] - hsEdge[0], hsEdge[2] - hsEdge[1]);
    end
  endtask

  task automatic test_lsb_w2();
    logic [4:0] expObs [5];
    expObs = '{5'b00000, 5'b11110, 5'b00000, 5'b11101, 5'b10000};
    @(negedge clk);
    validB = 1'b1; dataB = 2'b01;
    checks++;
    if (readyB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL w2_ready got %b want %b", readyB, 1'b1);
    end
    @(negedge clk);
    dataB = 2'b10;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({readyB, frameB, sofB, d0B, d1B} !== expObs[i]) begin
        errors++;
        $display("[TB] FAIL w2_cycle%0d got %b want %b", i, {readyB, frameB, sofB, d0B, d1B}, expObs[i]);
      end
      if (i == 2) validB = 1'b0;
      if (i < 4) @(negedge clk);
    end
    validB = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [1:0] expPair [4];
    expPair = '{2'b10, 2'b01, 2'b01, 2'b10};
    @(negedge clk);
    validA = 1'b1; dataA = 8'hC3;
    @(negedge clk);
    dataA = 8'h5A;
    @(negedge clk);
    checks++;
    if ({frameA, sofA, d0A, d1A} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL rmw_first_pair got %b want %b", {frameA, sofA, d0A, d1A}, 4'b1111);
    end
    @(negedge clk);
    validA = 1'b0; dataA = 8'h00;
    checks++;
    if ({readyA, frameA, sofA, d0A, d1A} !== 5'b01000) begin
      errors++;
      $display("[TB] FAIL rmw_second_pair got %b want %b", {readyA, frameA, sofA, d0A, d1A}, 5'b01000);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({readyA, frameA, sofA, d0A, d1A} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL rmw_async_clear got %b want %b", {readyA, frameA, sofA, d0A, d1A}, 5'b00000);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (readyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmw_ready_after got %b want %b", readyA, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (frameA !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rmw_residue%0d got %b want %b", i, frameA, 1'b0);
      end
    end
    validA = 1'b1; dataA = 8'h96;
    @(negedge clk);
    validA = 1'b0; dataA = 8'h00;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if ({frameA, sofA, d0A, d1A} !== {1'b1, 1'(j == 0), expPair[j]}) begin
        errors++;
        $display("[TB] FAIL rmw_next_pair%0d got %b want %b", j, {frameA, sofA, d0A, d1A},
                 {1'b1, 1'(j == 0), expPair[j]});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stalled();
    int         accepted, edgeN, freeEdge, holdUntil, lastEdge, start;
    logic       hs;
    logic [7:0] w;
    for (int i = 0; i < LIMIT + 16; i++) expOut[i] = 4'b0000;
    for (int i = 0; i < NWORDS; i++) stallWords[i] = 8'($urandom);
    accepted = 0; edgeN = 0; freeEdge = 1; holdUntil = 0; lastEdge = 0;
    @(negedge clk);
    while ((accepted < NWORDS || edgeN < lastEdge + 1) && edgeN < LIMIT) begin
      if (accepted < NWORDS && $urandom_range(0, 99) < 45) begin
        validA = 1'b1; dataA = stallWords[accepted];
      end else begin
        validA = 1'b0; dataA = 8'($urandom);
      end
      checks++;
      if (readyA !== 1'(edgeN >= holdUntil)) begin
        errors++;
        $display("[TB] FAIL stall_ready edge%0d got %b want %b", edgeN, readyA, 1'(edgeN >= holdUntil));
      end
      hs = validA && readyA;
      @(negedge clk);
      edgeN++;
      if (hs) begin
        // A word starts the edge after it is taken, or when the previous word ends.
        w = stallWords[accepted];
        start = (edgeN + 1 > freeEdge) ? edgeN + 1 : freeEdge;
        for (int j = 0; j < 4; j++)
          expOut[start + j] = {1'b1, 1'(j == 0), w[7 - 2*j], w[6 - 2*j]};
        freeEdge = start + 4; holdUntil = start; lastEdge = start + 3;
        accepted++;
      end
      checks++;
      if ({frameA, sofA, d0A, d1A} !== expOut[edgeN]) begin
        errors++;
        $display("[TB] FAIL stall_out edge%0d got %b want %b", edgeN, {frameA, sofA, d0A, d1A}, expOut[edgeN]);
      end
    end
    validA = 1'b0;
    checks++;
    if (accepted != NWORDS || edgeN < lastEdge) begin
      errors++;
      $display("[TB] FAIL stall_timeout got words=%0d edge=%0d want words=%0d", accepted, edgeN, NWORDS);
    end
  endtask

  initial begin
    int seedDummy;
    seedDummy = $urandom(32'd20240611);
    $display("[TB] start, seed draw %0d", seedDummy);
    test_reset();
    test_single_word();
    test_saturated();
    test_lsb_w2();
    test_reset_mid_word();
    test_stalled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
